// File: rtl/dmem_arbiter_pkg.sv
// Shared constants and types for the data-memory arbiter, the core and the DMEM.
package dmem_arbiter_pkg;

    localparam int DMEM_DEPTH = 32;
    localparam int DMEM_AW    = 5;
    localparam int DMEM_DW    = 32;
    localparam int WAIT_W     = 4;

    localparam logic [0:0] ST_ARB  = 1'b0;
    localparam logic [0:0] ST_LOCK = 1'b1;

    typedef enum logic [0:0] {
        ARB  = ST_ARB,
        LOCK = ST_LOCK
    } arb_state_t;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        CPU  = 2'd1,
        DBG  = 2'd2
    } port_id_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the data memory.
interface dmem_arbiter_if
    import dmem_arbiter_pkg::*;
#(
    parameter int AW = DMEM_AW,
    parameter int DW = DMEM_DW
);
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_gnt;
    logic          cpu_stall;
    logic          cpu_rvalid;
    logic [DW-1:0] cpu_rdata;

    logic          dbg_req;
    logic          dbg_we;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_wdata;
    logic          dbg_lock;
    logic          dbg_gnt;
    logic          dbg_rvalid;
    logic [DW-1:0] dbg_rdata;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_lock,
        output dbg_gnt, dbg_rvalid, dbg_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_lock,
        input  dbg_gnt, dbg_rvalid, dbg_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/dmem_arbiter.sv
// CPU-priority arbiter for the single-port DMEM with bounded debug wait and
// a debug lock mode for back-to-back preload bursts.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int AW       = DMEM_AW,
    parameter int DW       = DMEM_DW,
    parameter int MAX_WAIT = 4
) (
    input  logic                clk,
    input  logic                RN,
    dmem_arbiter_if.slave       bus
);

    localparam logic [WAIT_W-1:0] MAX_W = WAIT_W'(MAX_WAIT);

    arb_state_t        state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    port_id_t          rd_owner_q, rd_owner_d;
    logic              rn_q;

    logic          blk;
    logic          dbg_win;
    logic          cpu_gnt;
    logic          dbg_gnt;
    logic          cpu_rvalid;
    logic          dbg_rvalid;
    logic          mem_we_mux;
    logic [AW-1:0] addr_mux;
    logic [DW-1:0] wdata_mux;

    // Everything stays silent while in reset and for one cycle after it.
    assign blk = RN | rn_q;

    always_comb begin
        dbg_win = bus.dbg_req & (~bus.cpu_req | (wait_cnt_q == MAX_W));
        cpu_gnt = 1'b0;
        dbg_gnt = 1'b0;
        if (!blk) begin
            if (state_q == LOCK) begin
                dbg_gnt = bus.dbg_req;
            end else begin
                dbg_gnt = dbg_win;
                cpu_gnt = bus.cpu_req & ~dbg_win;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB:     if (dbg_gnt && bus.dbg_lock) state_d = LOCK;
            LOCK:    if (!(bus.dbg_lock && bus.dbg_req)) state_d = ARB;
            default: state_d = ARB;
        endcase
    end

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (!bus.dbg_req || dbg_gnt) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q != MAX_W) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end
    end

    always_comb begin
        rd_owner_d = NONE;
        if (cpu_gnt && !bus.cpu_we) begin
            rd_owner_d = CPU;
        end else if (dbg_gnt && !bus.dbg_we) begin
            rd_owner_d = DBG;
        end
    end

    always_comb begin
        mem_we_mux = 1'b0;
        addr_mux   = '0;
        wdata_mux  = '0;
        if (cpu_gnt) begin
            mem_we_mux = bus.cpu_we;
            addr_mux   = bus.cpu_addr;
            wdata_mux  = bus.cpu_wdata;
        end else if (dbg_gnt) begin
            mem_we_mux = bus.dbg_we;
            addr_mux   = bus.dbg_addr;
            wdata_mux  = bus.dbg_wdata;
        end
    end

    always_ff @(posedge clk) begin
        rn_q <= RN;
        if (RN) begin
            state_q    <= ARB;
            wait_cnt_q <= '0;
            rd_owner_q <= NONE;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            rd_owner_q <= rd_owner_d;
        end
    end

    assign cpu_rvalid = ~blk & (rd_owner_q == CPU);
    assign dbg_rvalid = ~blk & (rd_owner_q == DBG);

    assign bus.cpu_gnt    = cpu_gnt;
    assign bus.cpu_stall  = ~blk & bus.cpu_req & ~cpu_gnt;
    assign bus.cpu_rvalid = cpu_rvalid;
    assign bus.cpu_rdata  = cpu_rvalid ? bus.mem_rdata : '0;
    assign bus.dbg_gnt    = dbg_gnt;
    assign bus.dbg_rvalid = dbg_rvalid;
    assign bus.dbg_rdata  = dbg_rvalid ? bus.mem_rdata : '0;

    assign bus.mem_en    = cpu_gnt | dbg_gnt;
    assign bus.mem_we    = mem_we_mux;
    assign bus.mem_addr  = addr_mux;
    assign bus.mem_wdata = wdata_mux;

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Single-port arbiter sharing the 32x32 data memory between the pipeline's MEM stage and a debug/loader port. The pipeline has priority by default, with a bounded-wait guarantee for debug traffic. A lock mode allows back-to-back debug bursts for program/data preload. `cpu_stall` tells the pipeline to freeze IF–MEM whenever its access is not granted.

## Interface
- `AW`, 5: word address width; 32 words.
- `DW`, 32: data width.
- `MAX_WAIT`, 4: consecutive denied debug cycles before debug is forced ahead of the CPU; range 1–15.

Ports:
- `clk`  in  1  clock; everything is on the rising edge.
- `RN`  in  1  reset, synchronous, active-high.
- `cpu_req`  in  1  MEM-stage access request; held until granted.
- `cpu_we`  in  1  1 = store (SW), 0 = load (LW).
- `cpu_addr`  in  AW  word address.
- `cpu_wdata`  in  DW  store data.
- `cpu_gnt`  out  1  access accepted this cycle.
- `cpu_stall`  out  1  `cpu_req & ~cpu_gnt`.
- `cpu_rvalid`  out  1  load data valid.
- `cpu_rdata`  out  DW  load data; 0 when `cpu_rvalid` = 0.
- `dbg_req`, `dbg_we`, `dbg_addr`, `dbg_wdata`, `dbg_gnt`, `dbg_rvalid`, `dbg_rdata`: same widths and meanings as the `cpu_*` ports.
- `dbg_lock`  in  1  keep ownership after the current debug grant.
- `mem_en`  out  1  memory access strobe.
- `mem_we`  out  1  write enable.
- `mem_addr`  out  AW  address.
- `mem_wdata`  out  DW  write data.
- `mem_rdata`  in  DW  read data, valid the cycle after a read strobe.

## Operation
- **Transfer rule:** a transfer happens in any cycle where `req & gnt` on a port. At most one grant per cycle. Requesters must hold `req`, `we`, `addr` and `wdata` stable until granted.
- **States:**
  - **ARB** (reset state).
    - Debug is granted if `dbg_req & (~cpu_req | wait_cnt == MAX_WAIT)`.
    - Otherwise the CPU is granted if `cpu_req`.
    - Debug grant with `dbg_lock` = 1 → LOCK.
  - **LOCK**
    - Only debug can be granted; `cpu_gnt` = 0.
    - Stay while `dbg_lock & dbg_req`; otherwise → ARB in the next cycle.
    - LOCK has no timeout: a debug master holding the lock halts the CPU by design.
- **wait_cnt (4 bit):**
  - +1 each cycle with `dbg_req & ~dbg_gnt`, saturating at `MAX_WAIT`.
  - Cleared on debug grant or when `dbg_req` = 0.
- **Memory drive:**
  - `mem_en` = any grant.
  - `mem_we`, `mem_addr`, `mem_wdata` are muxed from the granted port.
  - When idle, `mem_en` = 0 and all other memory outputs are 0.
- **Read return:**
  - Registered `rd_owner` (NONE/CPU/DBG) is set on a read grant.
  - `x_rvalid` = (`rd_owner` == x) in the following cycle.
  - `x_rdata` = `mem_rdata` gated by `x_rvalid`.
- **Writes:** complete at the grant-cycle edge. No response signal.
- **Reset:**
  - `RN` forces state ARB, `wait_cnt` 0, `rd_owner` NONE.
  - All outputs read 0 during reset and in the first cycle after reset.
  - A read granted in the cycle `RN` rises returns no `rvalid`.

## Timing
- Grant is combinational from `req` (zero-wait when free). `mem_*` outputs are combinational from the grant.
- Read latency is 1 cycle from grant to `rvalid`. A new grant may issue in the same cycle as the previous `rvalid`, giving full throughput.
- **Debug latency:**
  - Worst-case wait under continuous CPU traffic is `MAX_WAIT` cycles.
  - Debug is granted in cycle `MAX_WAIT`+1 after `dbg_req` rises.
- LOCK exit takes 1 cycle. The CPU can be granted in the cycle after `dbg_lock` or `dbg_req` falls.
- No wrap-around logic: addresses are exactly `AW` bits.

## Structure
- Shared package holds:
  - enum `arb_state_t` {ARB, LOCK};
  - enum `port_id_t` {NONE, CPU, DBG};
  - memory depth/width constants, shared with the core and the DMEM.
- Single module; no sub-module. The saturating counter and owner register stay inline.

## Test plan
- CPU-only LW to addr 3 holding 0x0000_0005 → `cpu_gnt` in the same cycle, `cpu_rvalid` with `cpu_rdata` 0x5 the next cycle, `cpu_stall` never high.
- Simultaneous requests every cycle, `MAX_WAIT` = 4 → `cpu_gnt` cycles 0–3, `dbg_gnt` cycle 4, `wait_cnt` back to 0, `cpu_stall` high exactly in cycle 4.
- Debug locked burst, `dbg_lock` = 1: SW 0xA, 0xB, 0xC to addrs 0–2 while `cpu_req` is high → three consecutive `dbg_gnt`, CPU stalled 3 cycles, CPU granted the cycle after the lock drops.
- CPU read grant then debug read grant back-to-back → `cpu_rvalid` in cycle 1, `dbg_rvalid` in cycle 2, no cross-port data leakage (other port's rdata stays 0).
- `RN` asserted in the same cycle as a CPU read grant → no `rvalid` afterward, state ARB, all outputs 0.
- `dbg_req` dropped after 2 denied cycles, then reasserted → `wait_cnt` restarts from 0; grant comes `MAX_WAIT` cycles later, not 2.
